// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and codes for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int LINE_BITS_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - clearable cycle counter flagging the TIMEOUT-th enabled cycle
module arb_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // tc marks the enabled cycle that would be the TIMEOUT-th in a row
  assign o_tc = i_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data-cache miss paths
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int LINE_BITS     = LINE_BITS_DEF,
  parameter int MAX_DC_STREAK = 2,
  parameter int TIMEOUT       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_ack,
  output logic [LINE_BITS-1:0] if_rdata,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_ack,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int SW = $clog2(MAX_DC_STREAK + 1);

  arb_state_t            r_state;
  arb_state_t            w_next;
  logic [1:0]            r_owner;
  logic [SW-1:0]         r_streak;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [LINE_BITS-1:0]  r_mem_wdata;
  logic [LINE_BITS-1:0]  r_if_rdata;
  logic [LINE_BITS-1:0]  r_dc_rdata;
  logic                  r_timeout_err;
  logic                  w_any_req;
  logic                  w_grant_dc;
  logic                  w_tc;

  assign w_any_req  = if_req | dc_req;
  assign w_grant_dc = dc_req && (!if_req || (r_streak != SW'(MAX_DC_STREAK)));

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state != MEM),
    .i_en  ((r_state == MEM) && !mem_ack),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = MEM;
      MEM:     if (mem_ack || w_tc) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner       <= OWN_NONE;
      r_streak      <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_dc_rdata    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_dc) begin
            r_owner     <= OWN_DC;
            r_mem_we    <= dc_we;
            r_mem_addr  <= dc_addr;
            r_mem_wdata <= dc_wdata;
            // a DC grant with fetch waiting implies streak < MAX, so +1 saturates naturally
            r_streak    <= if_req ? r_streak + 1'b1 : '0;
          end else if (if_req) begin
            r_owner     <= OWN_IF;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_streak    <= '0;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (r_owner == OWN_IF) r_if_rdata <= mem_rdata;
            else                   r_dc_rdata <= mem_rdata;
          end else if (w_tc) begin
            r_timeout_err <= 1'b1;
            if (r_owner == OWN_IF) r_if_rdata <= '0;
            else                   r_dc_rdata <= '0;
          end
        end
        RESP:    r_owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

  assign mem_req     = (r_state == MEM);
  assign busy        = (r_state != IDLE);
  assign if_ack      = (r_state == RESP) && (r_owner == OWN_IF);
  assign dc_ack      = (r_state == RESP) && (r_owner == OWN_DC);
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign dc_rdata    = r_dc_rdata;
  assign owner       = r_owner;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int LB   = 64;
  localparam int MAXS = 2;
  localparam int TO   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [LB-1:0] if_rdata;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LB-1:0] dc_wdata = '0;
  logic          dc_ack;
  logic [LB-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LB-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LB-1:0] mem_rdata = '0;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout_err;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_BITS(LB), .MAX_DC_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; logic we; logic [LB-1:0] wdata; } req_t;
  req_t if_q[$];
  req_t dc_q[$];

  typedef struct {
    logic side_dc; logic we; logic [AW-1:0] addr; logic [LB-1:0] wdata;
    int lat; logic [LB-1:0] mdata;
    logic exp_we; logic [LB-1:0] exp_wdata; logic [LB-1:0] exp_rdata;
  } vec_t;
  vec_t vt[5];

  // Reference model: one outstanding transaction, described by who owns the port,
  // whether memory has finished, and how long memory has been waited on.
  int            m_owner = 0;
  bit            m_done = 0;
  int            m_wait = 0;
  int            m_streak = 0;
  bit            m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 1'b0;
  logic [LB-1:0] m_wdata = '0;
  logic [LB-1:0] m_if_rd = '0;
  logic [LB-1:0] m_dc_rd = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_owner = 0; m_done = 0; m_wait = 0; m_streak = 0; m_err = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0; m_if_rd = '0; m_dc_rd = '0;
    end else if (m_owner == 0) begin
      if (dc_req && (!if_req || m_streak < MAXS)) begin
        m_owner = 2; m_addr = dc_addr; m_we = dc_we; m_wdata = dc_wdata;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        m_done = 0; m_wait = 0;
      end else if (if_req) begin
        m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
        m_streak = 0; m_done = 0; m_wait = 0;
      end
    end else if (!m_done) begin
      if (mem_ack) begin
        if (m_owner == 1) m_if_rd = mem_rdata; else m_dc_rd = mem_rdata;
        m_done = 1;
      end else if (m_wait + 1 >= TO) begin
        if (m_owner == 1) m_if_rd = '0; else m_dc_rd = '0;
        m_err = 1; m_done = 1;
      end else begin
        m_wait++;
      end
    end else begin
      m_owner = 0; m_done = 0;
    end
  end

  bit            chk_en = 0;
  bit            rand_mode = 0;
  bit            force_ack = 0;
  int            mem_lat = 1;
  logic [LB-1:0] mem_data = '0;
  int            n_if_ack = 0;
  int            n_dc_ack = 0;
  int            n_mreq_cyc = 0;
  logic          prev_mreq = 1'b0;
  logic [1:0]    prev_owner = 2'd0;
  int            grants[$];
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [LB-1:0] cap_wdata;
  logic [LB-1:0] cap_rdata;
  logic          exp_mreq;

  always @(negedge clk) begin
    exp_mreq = (m_owner != 0) && !m_done;
    if (chk_en) begin
      chk("mem_req",     mem_req,     exp_mreq);
      chk("mem_we",      mem_we,      m_we);
      chk("mem_addr",    mem_addr,    m_addr);
      chk("mem_wdata",   mem_wdata,   m_wdata);
      chk("if_ack",      if_ack,      (m_owner == 1) && m_done);
      chk("dc_ack",      dc_ack,      (m_owner == 2) && m_done);
      chk("if_rdata",    if_rdata,    m_if_rd);
      chk("dc_rdata",    dc_rdata,    m_dc_rd);
      chk("owner",       owner,       m_owner);
      chk("busy",        busy,        m_owner != 0);
      chk("timeout_err", timeout_err, m_err);
    end
    if (if_ack) begin n_if_ack++; cap_rdata = if_rdata; end
    if (dc_ack) begin n_dc_ack++; cap_rdata = dc_rdata; end
    if (mem_req) n_mreq_cyc++;
    if (mem_req && !prev_mreq) begin cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata; end
    prev_mreq = mem_req;
    if (owner != prev_owner && owner != 2'd0) grants.push_back(int'(owner));
    prev_owner = owner;

    // requesters: pop on ack, scramble address/data while their request is in flight
    if (m_owner == 1 && m_done && if_q.size() > 0) if_q.delete(0);
    if (m_owner == 2 && m_done && dc_q.size() > 0) dc_q.delete(0);
    if (m_owner == 1 && !m_done) if_addr = AW'($urandom);
    else if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0].addr; end
    else if_req = 1'b0;
    if (m_owner == 2 && !m_done) begin
      dc_addr = AW'($urandom); dc_wdata = {$urandom, $urandom}; dc_we = 1'($urandom_range(0, 1));
    end else if (dc_q.size() > 0) begin
      dc_req = 1'b1; dc_addr = dc_q[0].addr; dc_we = dc_q[0].we; dc_wdata = dc_q[0].wdata;
    end else dc_req = 1'b0;

    // memory responder; mem_lat == 0 means memory never answers
    mem_ack = 1'b0;
    if (exp_mreq && mem_lat > 0 && m_wait == mem_lat - 1) mem_ack = 1'b1;
    if (rand_mode) begin
      mem_rdata = {$urandom, $urandom};
      if (!exp_mreq) begin
        mem_lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
        if ($urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
    end else begin
      mem_rdata = mem_data;
    end
    if (force_ack) mem_ack = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    if_q.delete(); dc_q.delete();
    tick(n);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    tick(1);
    while ((if_q.size() > 0 || dc_q.size() > 0 || m_owner != 0) && n < budget) begin
      tick(1); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_bound got=%0d exp<%0d", n, budget);
    end
  endtask

  int a_if, a_dc, pushed;
  int exp_ord[4] = '{2, 2, 1, 2};

  initial begin
    vt[0] = '{1'b0, 1'b0, 16'h0040, 64'h0, 3, 64'h1111_2222_3333_4444, 1'b0, 64'h0, 64'h1111_2222_3333_4444};
    vt[1] = '{1'b1, 1'b1, 16'h0100, 64'hDEAD_BEEF_0000_0001, 2, 64'h5A5A_0000_0000_A5A5,
              1'b1, 64'hDEAD_BEEF_0000_0001, 64'h5A5A_0000_0000_A5A5};
    vt[2] = '{1'b1, 1'b0, 16'h0200, 64'hFFFF_0000_FFFF_0000, 1, 64'hABCD_EF01_2345_6789,
              1'b0, 64'hFFFF_0000_FFFF_0000, 64'hABCD_EF01_2345_6789};
    vt[3] = '{1'b0, 1'b0, 16'hFFC0, 64'h0, 5, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF};
    vt[4] = '{1'b1, 1'b0, 16'h0008, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

    do_reset(3);
    chk("rst_owner", owner, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_if_rdata", if_rdata, 64'h0);
    chk_en = 1;

    for (int i = 0; i < 5; i++) begin
      mem_lat = vt[i].lat; mem_data = vt[i].mdata;
      a_if = n_if_ack; a_dc = n_dc_ack;
      if (vt[i].side_dc) dc_q.push_back('{addr: vt[i].addr, we: vt[i].we, wdata: vt[i].wdata});
      else               if_q.push_back('{addr: vt[i].addr, we: 1'b0, wdata: '0});
      wait_drain(100);
      chk($sformatf("vec%0d_addr", i), cap_addr, vt[i].addr);
      chk($sformatf("vec%0d_we", i), cap_we, vt[i].exp_we);
      chk($sformatf("vec%0d_wdata", i), cap_wdata, vt[i].exp_wdata);
      chk($sformatf("vec%0d_rdata", i), cap_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_if_acks", i), n_if_ack - a_if, vt[i].side_dc ? 0 : 1);
      chk($sformatf("vec%0d_dc_acks", i), n_dc_ack - a_dc, vt[i].side_dc ? 1 : 0);
    end

    // starvation guard: fetch waits through at most MAXS data grants
    do_reset(2);
    mem_lat = 2; grants.delete();
    if_q.push_back('{addr: 16'h0300, we: 1'b0, wdata: '0});
    for (int i = 0; i < 3; i++) dc_q.push_back('{addr: AW'(16'h0400 + 16'(i * 8)), we: 1'b0, wdata: '0});
    wait_drain(200);
    chk("starve_count", grants.size(), 4);
    if (grants.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("starve_grant%0d", i), grants[i], exp_ord[i]);

    // simultaneous requests straight out of reset
    do_reset(2);
    grants.delete();
    if_q.push_back('{addr: 16'h0500, we: 1'b0, wdata: '0});
    dc_q.push_back('{addr: 16'h0600, we: 1'b1, wdata: 64'h0F0F});
    wait_drain(100);
    chk("simul_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("simul_first", grants[0], 2);
      chk("simul_second", grants[1], 1);
    end

    // random traffic with stray acks and occasional timeouts
    rand_mode = 1; pushed = 0; a_if = n_if_ack; a_dc = n_dc_ack;
    repeat (400) begin
      tick(1);
      if ($urandom_range(0, 3) == 0 && if_q.size() < 2) begin
        if_q.push_back('{addr: AW'($urandom), we: 1'b0, wdata: '0}); pushed++;
      end
      if ($urandom_range(0, 2) == 0 && dc_q.size() < 2) begin
        dc_q.push_back('{addr: AW'($urandom), we: 1'($urandom_range(0, 1)), wdata: {$urandom, $urandom}});
        pushed++;
      end
    end
    wait_drain(1000);
    rand_mode = 0;
    chk("rand_acks", (n_if_ack - a_if) + (n_dc_ack - a_dc), pushed);

    // watchdog: prime dc_rdata with a nonzero line, then let memory hang
    do_reset(2);
    tick(1);
    mem_lat = 2; mem_data = 64'hFEED_FACE_CAFE_0001;
    dc_q.push_back('{addr: 16'h0700, we: 1'b0, wdata: '0});
    wait_drain(100);
    chk("to_pre_err", timeout_err, 1'b0);
    chk("to_pre_rdata", dc_rdata, 64'hFEED_FACE_CAFE_0001);
    mem_lat = 0; n_mreq_cyc = 0; a_dc = n_dc_ack;
    dc_q.push_back('{addr: 16'h0740, we: 1'b0, wdata: '0});
    wait_drain(200);
    chk("to_mreq_cycles", n_mreq_cyc, TO);
    chk("to_acks", n_dc_ack - a_dc, 1);
    chk("to_rdata", cap_rdata, 64'h0);
    chk("to_err", timeout_err, 1'b1);
    tick(5);
    chk("to_err_sticky", timeout_err, 1'b1);

    // reset in the middle of MEM, followed by a late mem_ack
    mem_lat = 0;
    if_q.push_back('{addr: 16'h0080, we: 1'b0, wdata: '0});
    tick(4);
    chk("mid_mem_req", mem_req, 1'b1);
    a_if = n_if_ack; a_dc = n_dc_ack;
    reset = 1'b0; if_q.delete();
    tick(1);
    reset = 1'b1; force_ack = 1;
    tick(1);
    force_ack = 0;
    tick(4);
    chk("mid_acks", (n_if_ack - a_if) + (n_dc_ack - a_dc), 0);
    chk("mid_owner", owner, 2'd0);
    chk("mid_mem_req_after", mem_req, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_err", timeout_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
